// File: rtl/modport_axi_slave.sv
// AXI3-style word-memory slave: independent single-burst write and read FSMs.
// Optional WRAP burst support is enabled by defining MODPORT_AXI_SLAVE_WRAP_EN.
module modport_axi_slave #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        aclk,
  input  logic        arst,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awqos,
  input  logic        awregion,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arqos,
  input  logic        arregion,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int          AW      = $clog2(MEM_DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;
`ifdef MODPORT_AXI_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [31:0] mem [MEM_DEPTH];

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [3:0] len);
    logic wrap_ok;
    wrap_ok = WRAP_EN && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    burst_legal = (size <= 3'd2) && (burst != 2'b11) && ((burst != 2'b10) || wrap_ok);
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    in_range = a[31:2] < DEPTH_W;
  endfunction

  // WRAP keeps the unaligned low bits and folds the carry back into the window.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [2:0] size, input logic [3:0] len);
    logic [31:0] incr, bnd;
    incr = 32'd1 << size;
    bnd  = incr * ({28'd0, len} + 32'd1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~(bnd - 32'd1)) | ((a + incr) & (bnd - 32'd1));
      default: next_addr = (a & ~(incr - 32'd1)) + incr;
    endcase
  endfunction

  // ---------------- write path ----------------
  wstate_t     w_state;
  logic [3:0]  w_id, w_len, w_cnt;
  logic [31:0] w_addr;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_bad, w_err;

  logic w_fire, w_beat_ok, w_last_beat, w_beat_err;
  assign w_fire      = wvalid && wready;
  assign w_beat_ok   = !w_bad && in_range(w_addr);
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = !w_beat_ok || (wlast != w_last_beat);

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= OKAY;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_bad   <= !burst_legal(awburst, awsize, awlen);
            w_cnt   <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_burst, w_size, w_len);
            w_cnt  <= w_cnt + 4'd1;
            // Beat count, not wlast, decides where the burst ends.
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || w_beat_err) ? SLVERR : OKAY;
              w_state <= W_RESP;
            end else begin
              w_err <= w_err || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge aclk) begin
    if (w_fire && w_beat_ok) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read path ----------------
  rstate_t     r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_bad;

  logic [31:0] rd_a, rd_word;
  logic        rd_bad, rd_ok;

  // Address of the beat about to be loaded: the AR address when idle, else the successor.
  always_comb begin
    rd_a   = araddr;
    rd_bad = !burst_legal(arburst, arsize, arlen);
    if (r_state == R_DATA) begin
      rd_a   = next_addr(r_addr, r_burst, r_size, r_len);
      rd_bad = r_bad;
    end
    rd_ok   = !rd_bad && in_range(rd_a);
    rd_word = mem[rd_a[AW+1:2]];
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= OKAY;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_bad   <= rd_bad;
            r_cnt   <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rid     <= arid;
            rdata   <= rd_ok ? rd_word : 32'd0;
            rresp   <= rd_ok ? OKAY : SLVERR;
            rlast   <= (arlen == 4'd0);
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rid     <= '0;
              rdata   <= '0;
              rresp   <= OKAY;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= rd_a;
              r_cnt  <= r_cnt + 4'd1;
              rdata  <= rd_ok ? rd_word : 32'd0;
              rresp  <= rd_ok ? OKAY : SLVERR;
              rlast  <= (r_cnt + 4'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, awqos, awregion, wid,
                             arlock, arcache, arprot, arqos, arregion};

endmodule

// File: tb/tb_modport_axi_slave.sv
// Directed + randomized bench for modport_axi_slave against a burst-level memory model.
module tb_modport_axi_slave;
  localparam int MEM_DEPTH = 1024;
`ifdef MODPORT_AXI_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic aclk = 1'b0, arst = 1'b1;
  logic [3:0] awid = '0, awlen = '0, awcache = 4'h3, wid = '0, wstrb = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0] awsize = '0, awprot = 3'h1, arsize = '0, arprot = 3'h2;
  logic [1:0] awburst = '0, awlock = 2'b01, arburst = '0, arlock = 2'b01;
  logic awqos = 1'b1, awregion = 1'b1, awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0] arid = '0, arlen = '0, arcache = 4'h5;
  logic arqos = 1'b0, arregion = 1'b1, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;

  modport_axi_slave #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int vecs = 0, errs = 0;
  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_got [16];
  logic [1:0]  last_bresp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model (burst rules in closed form) ----
  function automatic bit m_legal(input logic [1:0] burst, input logic [2:0] size, input logic [3:0] len);
    if (size > 3'd2 || burst == 2'b11) return 1'b0;
    if (burst == 2'b10) return WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a0, input logic [1:0] burst,
                                         input logic [2:0] size, input logic [3:0] len, input int i);
    logic [31:0] incr, bnd, base;
    incr = 32'd1 << size;
    if (burst == 2'b00) return a0;
    if (burst == 2'b10) begin
      bnd  = incr * (32'(len) + 1);
      base = a0 & ~(bnd - 1);
      return base + ((a0 - base + 32'(i) * incr) % bnd);
    end
    if (i == 0) return a0;
    return (a0 & ~(incr - 1)) + 32'(i) * incr;
  endfunction

  function automatic bit m_inr(input logic [31:0] a);
    return (a >> 2) < MEM_DEPTH;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad_last);
    bit ok;
    logic [1:0] eresp;
    logic [31:0] ba;
    int t;
    ok = m_legal(burst, size, len);
    eresp = ok ? 2'b00 : 2'b10;
    @(negedge aclk);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    chk("aw_handshake", 32'(t < 50), 32'd1);
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    chk("wready_rise", 32'(wready), 32'd1);
    chk("awready_low", 32'(awready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = (i == int'(len)) ^ (i == bad_last);
      chk("wready_beat", 32'(wready), 32'd1);
      ba = m_addr(a, burst, size, len, i);
      if (!ok || !m_inr(ba)) eresp = 2'b10;
      else
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[ba >> 2][8*b +: 8] = wd[i][8*b +: 8];
      if (wlast != (i == int'(len))) eresp = 2'b10;
      @(posedge aclk); @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_rise", 32'(bvalid), 32'd1);
    chk("wready_drop", 32'(wready), 32'd0);
    chk("bresp", 32'(bresp), 32'(eresp));
    chk("bid", 32'(bid), 32'(id));
    @(posedge aclk); @(negedge aclk);
    chk("bvalid_hold", 32'(bvalid), 32'd1);
    chk("bresp_hold", 32'(bresp), 32'(eresp));
    last_bresp = bresp;
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    bit ok;
    logic [31:0] ba, ed;
    logic [1:0] er;
    int t;
    ok = m_legal(burst, size, len);
    @(negedge aclk);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    chk("ar_handshake", 32'(t < 50), 32'd1);
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    chk("arready_low", 32'(arready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      ba = m_addr(a, burst, size, len, i);
      if (ok && m_inr(ba)) begin ed = ref_mem[ba >> 2]; er = 2'b00; end
      else begin ed = 32'd0; er = 2'b10; end
      if (i == stall_beat) begin
        rready = 1'b0;
        repeat (3) begin
          @(posedge aclk); @(negedge aclk);
          chk("rvalid_stall", 32'(rvalid), 32'd1);
          chk("rdata_stall", rdata, ed);
        end
        rready = 1'b1;
      end
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, ed);
      chk("rresp", 32'(rresp), 32'(er));
      chk("rlast", 32'(rlast), 32'(i == int'(len)));
      chk("rid", 32'(rid), 32'(id));
      rd_got[i] = rdata;
      @(posedge aclk); @(negedge aclk);
    end
    rready = 1'b0;
    chk("rvalid_end", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [31:0] a;
    int bl;

    // reset state
    #12;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    @(negedge aclk); @(negedge aclk);
    arst = 1'b0;
    chk("rel_awready", 32'(awready), 32'd0);
    @(posedge aclk); @(negedge aclk);
    chk("first_edge_awready", 32'(awready), 32'd1);
    chk("first_edge_arready", 32'(arready), 32'd1);

    // fill memory so every word is known to the model
    for (int k = 0; k < MEM_DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'(k), 32'(k * 64), 4'd15, 3'd2, 2'b01, -1);
    end

    // single write / read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h3, 32'h10, 4'd0, 3'd2, 2'b01, -1);
    chk("single_bresp", 32'(last_bresp), 32'd0);
    do_read(4'h6, 32'h10, 4'd0, 3'd2, 2'b01, -1);
    chk("single_rdata", rd_got[0], 32'hDEADBEEF);

    // INCR burst
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'h1, 32'h100, 4'd3, 3'd2, 2'b01, -1);
    do_read(4'h2, 32'h100, 4'd3, 3'd2, 2'b01, -1);
    for (int i = 0; i < 4; i++) chk("incr_rdata", rd_got[i], 32'(i + 1));

    // WRAP burst
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 5); ws[i] = 4'hF; end
    do_write(4'h4, 32'h108, 4'd3, 3'd2, 2'b10, -1);
    chk("wrap_bresp", 32'(last_bresp), WRAP_EN ? 32'd0 : 32'd2);
    do_read(4'h5, 32'h100, 4'd3, 3'd2, 2'b01, -1);
    chk("wrap_word0", rd_got[0], WRAP_EN ? 32'd7 : 32'd1);
    chk("wrap_word2", rd_got[2], WRAP_EN ? 32'd5 : 32'd3);
    do_read(4'h5, 32'h108, 4'd3, 3'd2, 2'b10, -1);

    // strobes
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(4'h7, 32'h200, 4'd0, 3'd2, 2'b01, -1);
    wd[0] = 32'h00000000; ws[0] = 4'b0101;
    do_write(4'h7, 32'h200, 4'd0, 3'd2, 2'b01, -1);
    do_read(4'h7, 32'h200, 4'd0, 3'd2, 2'b01, -1);
    chk("strobe_rdata", rd_got[0], 32'hFF00FF00);

    // out of range, burst crossing the top, illegal size/burst, wlast mismatch
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    do_write(4'h8, 32'(MEM_DEPTH * 4), 4'd0, 3'd2, 2'b01, -1);
    chk("oor_bresp", 32'(last_bresp), 32'd2);
    do_read(4'h8, 32'(MEM_DEPTH * 4), 4'd0, 3'd2, 2'b01, -1);
    chk("oor_rdata", rd_got[0], 32'd0);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'h9, 32'(MEM_DEPTH * 4 - 8), 4'd3, 3'd2, 2'b01, -1);
    do_read(4'h9, 32'(MEM_DEPTH * 4 - 8), 4'd3, 3'd2, 2'b01, -1);
    do_write(4'hA, 32'h300, 4'd1, 3'd3, 2'b01, -1);
    do_write(4'hA, 32'h300, 4'd1, 3'd2, 2'b11, -1);
    do_read(4'hA, 32'h300, 4'd1, 3'd3, 2'b01, -1);
    do_read(4'hA, 32'h300, 4'd1, 3'd2, 2'b11, -1);
    do_write(4'hB, 32'h340, 4'd2, 3'd2, 2'b01, 0);
    chk("wlast_bresp", 32'(last_bresp), 32'd2);
    do_read(4'hB, 32'h340, 4'd2, 3'd2, 2'b01, 1);

    // concurrent write and read on disjoint regions
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(4'hC, 32'h800, 4'd7, 3'd2, 2'b01, -1);
      do_read(4'hD, 32'h400, 4'd7, 3'd2, 2'b01, -1);
    join

    // randomized bursts
    for (int n = 0; n < 40; n++) begin
      len   = 4'($urandom_range(0, 15));
      size  = ($urandom_range(0, 9) < 7) ? 3'd2 : 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 4'((2 << $urandom_range(0, 3)) - 1);
      a  = 32'($urandom_range(0, MEM_DEPTH * 4 + 63));
      bl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(4'($urandom), a, len, size, burst, bl);
      do_read(4'($urandom), a, len, size, burst,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1);
    end

    // reset mid-burst
    @(negedge aclk);
    arid = 4'h1; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    chk("mid_rvalid_before", 32'(rvalid), 32'd1);
    #1 arst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    rready = 1'b0;
    @(negedge aclk); @(negedge aclk);
    arst = 1'b0;
    @(posedge aclk); @(negedge aclk);
    chk("post_rst_arready", 32'(arready), 32'd1);
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    do_read(4'h2, 32'h10, 4'd0, 3'd2, 2'b01, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
